// File: rtl/encoder4x2_pend.sv
// encoder4x2_pend: registered 4-to-2 priority encoder with a pending-request
// register and a valid/ack handshake. Requests (edges or levels of line) are
// latched into pending. The highest pending index is offered on code and
// held until ack. Requests that arrive during an offer wait; they cannot
// preempt it.
module encoder4x2_pend #(
  parameter bit EDGE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] line,
  input  logic       ack,
  output logic [1:0] code,
  output logic       valid,
  output logic [3:0] pending,
  output logic       overflow
);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t     state_q, state_d;
  logic [3:0] prev_q;
  logic [3:0] pending_q, pending_d;
  logic [1:0] code_q, code_d;
  logic       valid_q, valid_d;
  logic       overflow_q, overflow_d;
  logic [3:0] rise;
  logic [3:0] clr;

  // Bit 3 has the highest priority. An all-zero vector maps to 0.
  function automatic logic [1:0] prioEnc(input logic [3:0] v);
    if (v[3])      return 2'd3;
    else if (v[2]) return 2'd2;
    else if (v[1]) return 2'd1;
    else           return 2'd0;
  endfunction

  // Event detection, the granted-bit clear, and the pending/overflow next state.
  // A set takes priority over a clear, so an event that arrives in the ack cycle is kept.
  always_comb begin
    rise       = EDGE ? (line & ~prev_q) : line;
    clr        = ((state_q == OFFER) && ack) ? (4'b0001 << code_q) : 4'b0000;
    pending_d  = (pending_q & ~clr) | rise;
    overflow_d = |(rise & pending_q & ~clr);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: grant from IDLE when work is pending, and return on ack.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pending_q != 4'b0000) state_d = OFFER;
      OFFER:   if (ack)                  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: latch the code at grant time and hold it (even while idle).
  always_comb begin
    code_d  = code_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (pending_q != 4'b0000) begin
          code_d  = prioEnc(pending_q);
          valid_d = 1'b1;
        end
      end
      OFFER: begin
        if (ack) valid_d = 1'b0;
      end
      default: valid_d = 1'b0;
    endcase
  end

  // Datapath registers: line history, pending set, and the registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q     <= 4'b0000;
      pending_q  <= 4'b0000;
      code_q     <= 2'b00;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      prev_q     <= line;
      pending_q  <= pending_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  end

  assign code     = code_q;
  assign valid    = valid_q;
  assign pending  = pending_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_encoder4x2_pend.sv
// Self-checking bench for encoder4x2_pend (EDGE=1). Expected grant codes are
// queued when requests are driven. They are popped and compared when the DUT
// raises valid.
module tb_encoder4x2_pend;

  logic       clk;
  logic       rst;
  logic [3:0] line;
  logic       ack;
  logic [1:0] code;
  logic       valid;
  logic [3:0] pending;
  logic       overflow;

  int checks;
  int failures;
  logic [1:0] expQ[$];
  logic [1:0] expCode;

  encoder4x2_pend #(.EDGE(1'b1)) dut (
    .clk      (clk),
    .rst      (rst),
    .line     (line),
    .ack      (ack),
    .code     (code),
    .valid    (valid),
    .pending  (pending),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge. Sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst  = 1'b1;
    line = 4'b0000;
    ack  = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    line = 4'b1111;
    ack  = 1'b0;
    repeat (2) tick();
    checks++;
    if ({code, valid, pending, overflow} !== 8'b0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got=%b want=00000000", {code, valid, pending, overflow});
    end
    rst = 1'b0;
    tick();
    expQ.push_back(2'd3);
    checks++;
    if (pending !== 4'b1111 || valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_first_edge pending=%b valid=%b want 1111/0", pending, valid);
    end
    tick();
    expCode = (expQ.size() > 0) ? expQ.pop_front() : 2'bxx;
    checks++;
    if (valid !== 1'b1 || code !== expCode) begin
      failures++;
      $display("[TB] FAIL reset_grant valid=%b code=%0d want 1/%0d", valid, code, expCode);
    end
    // Asynchronous reset during an offer drops everything at once.
    rst = 1'b1;
    #1;
    checks++;
    if (valid !== 1'b0 || pending !== 4'b0000 || code !== 2'b00) begin
      failures++;
      $display("[TB] FAIL reset_in_offer valid=%b pending=%b code=%0d want 0/0000/0", valid, pending, code);
    end
    doReset();
  endtask

  task automatic test_single();
    line = 4'b0100;
    tick();
    line = 4'b0000;
    expQ.push_back(2'd2);
    checks++;
    if (pending !== 4'b0100 || valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_pending pending=%b valid=%b want 0100/0", pending, valid);
    end
    tick();
    expCode = (expQ.size() > 0) ? expQ.pop_front() : 2'bxx;
    checks++;
    if (valid !== 1'b1 || code !== expCode) begin
      failures++;
      $display("[TB] FAIL single_grant valid=%b code=%0d want 1/%0d", valid, code, expCode);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++;
    if (valid !== 1'b0 || pending !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL single_ack valid=%b pending=%b want 0/0000", valid, pending);
    end
  endtask

  task automatic test_no_preempt();
    doReset();
    line = 4'b0001;
    tick();
    line = 4'b0000;
    expQ.push_back(2'd0);
    tick();
    expCode = (expQ.size() > 0) ? expQ.pop_front() : 2'bxx;
    checks++;
    if (valid !== 1'b1 || code !== expCode) begin
      failures++;
      $display("[TB] FAIL preempt_first valid=%b code=%0d want 1/%0d", valid, code, expCode);
    end
    line = 4'b1000;
    tick();
    line = 4'b0000;
    expQ.push_back(2'd3);
    tick();
    checks++;
    if (valid !== 1'b1 || code !== 2'd0 || pending !== 4'b1001) begin
      failures++;
      $display("[TB] FAIL preempt_hold valid=%b code=%0d pending=%b want 1/0/1001", valid, code, pending);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++;
    if (valid !== 1'b0 || pending !== 4'b1000) begin
      failures++;
      $display("[TB] FAIL preempt_gap valid=%b pending=%b want 0/1000", valid, pending);
    end
    tick();
    expCode = (expQ.size() > 0) ? expQ.pop_front() : 2'bxx;
    checks++;
    if (valid !== 1'b1 || code !== expCode) begin
      failures++;
      $display("[TB] FAIL preempt_second valid=%b code=%0d want 1/%0d", valid, code, expCode);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [3:0] expPend;
    doReset();
    line = 4'b1110;
    tick();
    line = 4'b0000;
    expQ.push_back(2'd3);
    expQ.push_back(2'd2);
    expQ.push_back(2'd1);
    expPend = 4'b1110;
    tick();
    for (int i = 0; i < 3; i++) begin
      expCode = (expQ.size() > 0) ? expQ.pop_front() : 2'bxx;
      checks++;
      if (valid !== 1'b1 || code !== expCode) begin
        failures++;
        $display("[TB] FAIL order_grant%0d valid=%b code=%0d want 1/%0d", i, valid, code, expCode);
      end
      expPend = expPend & ~(4'b0001 << expCode);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      checks++;
      if (valid !== 1'b0 || pending !== expPend) begin
        failures++;
        $display("[TB] FAIL order_gap%0d valid=%b pending=%b want 0/%b", i, valid, pending, expPend);
      end
      if (i < 2) tick();
    end
  endtask

  task automatic test_overflow();
    doReset();
    line = 4'b0100;
    tick();
    line = 4'b0000;
    expQ.push_back(2'd2);
    tick();
    expCode = (expQ.size() > 0) ? expQ.pop_front() : 2'bxx;
    checks++;
    if (valid !== 1'b1 || code !== expCode || overflow !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ovf_grant valid=%b code=%0d ovf=%b want 1/%0d/0", valid, code, overflow, expCode);
    end
    line = 4'b0100;
    tick();
    line = 4'b0000;
    checks++;
    if (overflow !== 1'b1 || pending !== 4'b0100) begin
      failures++;
      $display("[TB] FAIL ovf_pulse ovf=%b pending=%b want 1/0100", overflow, pending);
    end
    tick();
    checks++;
    if (overflow !== 1'b0 || valid !== 1'b1 || code !== 2'd2) begin
      failures++;
      $display("[TB] FAIL ovf_one_cycle ovf=%b valid=%b code=%0d want 0/1/2", overflow, valid, code);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic test_collision();
    doReset();
    line = 4'b0010;
    tick();
    line = 4'b0000;
    expQ.push_back(2'd1);
    tick();
    expCode = (expQ.size() > 0) ? expQ.pop_front() : 2'bxx;
    checks++;
    if (valid !== 1'b1 || code !== expCode) begin
      failures++;
      $display("[TB] FAIL coll_grant valid=%b code=%0d want 1/%0d", valid, code, expCode);
    end
    ack  = 1'b1;
    line = 4'b0010;
    tick();
    ack  = 1'b0;
    line = 4'b0000;
    expQ.push_back(2'd1);
    checks++;
    if (valid !== 1'b0 || pending !== 4'b0010 || overflow !== 1'b0) begin
      failures++;
      $display("[TB] FAIL coll_keep valid=%b pending=%b ovf=%b want 0/0010/0", valid, pending, overflow);
    end
    tick();
    expCode = (expQ.size() > 0) ? expQ.pop_front() : 2'bxx;
    checks++;
    if (valid !== 1'b1 || code !== expCode) begin
      failures++;
      $display("[TB] FAIL coll_regrant valid=%b code=%0d want 1/%0d", valid, code, expCode);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    // A spurious ack while idle must not change anything.
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++;
    if (valid !== 1'b0 || code !== 2'd1 || pending !== 4'b0000 || overflow !== 1'b0) begin
      failures++;
      $display("[TB] FAIL spurious_ack valid=%b code=%0d pending=%b ovf=%b want 0/1/0000/0", valid, code, pending, overflow);
    end
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_leftover got=%0d want=0", expQ.size());
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst  = 1'b1;
    line = 4'b0000;
    ack  = 1'b0;
    test_reset();
    test_single();
    test_no_preempt();
    test_back_to_back();
    test_overflow();
    test_collision();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/encoder4x2_pend.md
# encoder4x2_pend

Registered 4-to-2 priority encoder with request latching and a valid/ack handshake. It is the encoding counterpart of the 2-4 decoder. Four request lines are captured into a pending register. The highest-priority pending line is presented as a 2-bit code and held until the consumer acknowledges it. The block sits between raw event or interrupt lines and any unit that services one request per handshake.

## Interface
Parameters:
- EDGE, 1, 1 = latch rising edges of `line`; 0 = latch level (any high bit sets pending every cycle).

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- line  input  4  request lines, synchronous to clk; bit 3 highest priority, bit 0 lowest.
- ack  input  1  consumer acknowledge; effective only when valid=1.
- code  output  2  index of the granted request; registered.
- valid  output  1  code is presented and awaiting ack; registered.
- pending  output  4  current pending-request register.
- overflow  output  1  one-cycle pulse: a new event hit an already-pending bit; registered.

## Operation
- State: prev[3:0], pending[3:0], FSM {IDLE, OFFER}, code, valid, overflow.
- Event vector:
  - EDGE=1: rise = line & ~prev, with prev <= line each cycle.
  - EDGE=0: rise = line.
- Clear vector: clr = onehot(code) when state=OFFER and ack=1; otherwise 0.
- Pending update each cycle: pending <= (pending & ~clr) | rise. Set wins over clear for the same bit.
- Overflow pulse: overflow <= |(rise & pending & ~clr). It is high for exactly one cycle per offending edge.
- FSM in IDLE:
  - If pending != 0: code <= index of highest set bit of pending; valid <= 1; go to OFFER.
  - Otherwise stay in IDLE; valid=0.
- FSM in OFFER:
  - code and valid are held stable.
  - A higher-priority arrival does not preempt; it waits in pending.
  - If ack=1: valid <= 0; clear the granted bit via clr; go to IDLE.
- ack while valid=0 is ignored, with no state change.
- code keeps its last value while valid=0.
- Priority encode on pending: 1xxx->3, 01xx->2, 001x->1, 0001->0.

## Timing
- Reset values (asynchronous, immediate on rst=1):
  - code=2'b00, valid=0, pending=4'b0000, overflow=0, prev=4'b0000, state=IDLE.
- EDGE=1 and a line held high through reset: the first sampled edge after reset release counts as a rise.
- Latency:
  - line rise sampled at edge k -> pending bit visible after edge k.
  - valid=1 with code after edge k+1 if the FSM was in IDLE.
- Ack:
  - sampled at edge m with valid=1 -> valid=0 and the bit cleared after edge m.
  - Next grant at the earliest after edge m+1, so there is at least one valid=0 cycle between grants.
- Throughput: at most one grant per 2 cycles when ack is returned immediately.
- Simultaneous rises on several lines in one cycle are all latched; they are granted in priority order, one per handshake.
- Same bit rises in the same cycle it is acked: the bit stays pending (new event), overflow=0, and it is re-granted later.
- rst asserted during OFFER: valid drops and pending clears immediately. The request is lost and no ack is expected.

## Test plan
- Reset: hold rst=1 with line=4'b1111, EDGE=1 -> all outputs 0. Release rst -> pending=4'b1111 after the first edge; valid=1 and code=3 one edge later.
- Single request: line pulses 4'b0100 for one cycle -> pending=4'b0100, then code=2 and valid=1. ack=1 for one cycle -> valid=0 and pending=0 the next edge.
- Priority and no preemption: line=4'b0001 rises, code=0 presented; then line 3 rises while in OFFER -> code stays 0. After ack -> one idle cycle, then code=3.
- Ordering: lines 1, 2 and 3 rise together; ack each grant immediately -> codes 3, 2, 1 in order, with valid low for exactly one cycle between them.
- Overflow: line 2 pulses twice while bit 2 is pending and unacked -> overflow=1 for exactly one cycle on the second edge; pending unchanged.
- Ack/rise collision and spurious ack: ack code=1 in the same cycle line 1 rises again -> pending bit 1 stays set, overflow=0, code=1 re-granted. An ack with valid=0 leaves all outputs unchanged.
